led_shift_engine: RTL

- Parametrised successor of the 8-bit left/right running-light shifter.
- Generalised to WIDTH bits with a built-in tick prescaler.
- Four run modes: rotate left, rotate right, ping-pong bounce, Johnson fill.
- Adds parallel load, enable and direction/tick status outputs.
- Sits between the board clock and the LED bank; drives Q straight to the LEDs.

---
 rtl/led_shift_pkg.sv | 18 +
 rtl/shift_tick_div.sv | 56 +++++
 rtl/led_shift_engine.sv | 114 +++++++++++
 3 files changed

// File: rtl/led_shift_pkg.sv
// Shared constants for the LED shift engine: run-mode codes, bounce directions and prescaler sizing.
// Optional speed-select build is enabled with LED_SPEED_SEL_EN.
package led_shift_pkg;

    localparam logic [1:0] MODE_ROTL    = 2'b00;
    localparam logic [1:0] MODE_ROTR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Prescaler counter width: enough bits to hold DIV-1, never narrower than one bit.
    function automatic int div_cw(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/shift_tick_div.sv
// Step prescaler: emits step_pulse once every DIV enabled cycles; clr restarts the count.
// With LED_SPEED_SEL_EN defined, a speed input divides the period by 1/2/4/8.
module shift_tick_div #(
    parameter int DIV = 50000000,
    parameter int CW  = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
`ifdef LED_SPEED_SEL_EN
    input  logic [1:0] speed,
`endif
    output logic       step_pulse
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] thr;
    logic          thr_hit;

`ifdef LED_SPEED_SEL_EN
    logic [31:0] scaled_div;

    always_comb begin
        scaled_div = 32'(DIV) >> speed;
        thr        = (scaled_div == 32'd0) ? '0 : CW'(scaled_div - 32'd1);
    end

    // A speed increase can leave the count above the new threshold; that wraps immediately.
    assign thr_hit = (count_q >= thr);
`else
    assign thr     = CW'(DIV - 1);
    assign thr_hit = (count_q == thr);
`endif

    assign step_pulse = en && !clr && thr_hit;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = step_pulse ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_shift_engine.sv
// Running-light engine: rotate, bounce and Johnson patterns stepped by an internal prescaler.
// Define LED_SPEED_SEL_EN to add the speed[1:0] rate-select input.
module led_shift_engine
    import led_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef LED_SPEED_SEL_EN
    input  logic [1:0]       speed,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             dir,
    output logic             tick
);

    localparam int CW = div_cw(DIV);

    logic             step;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] rotl, rotr, johnson;
    logic [WIDTH-1:0] stepped_q;
    logic             stepped_dir;

    shift_tick_div #(
        .DIV(DIV),
        .CW (CW)
    ) u_tick_div (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (load),
`ifdef LED_SPEED_SEL_EN
        .speed     (speed),
`endif
        .step_pulse(step)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rotl[gi] = q_q[(gi + WIDTH - 1) % WIDTH];
            assign rotr[gi] = q_q[(gi + 1) % WIDTH];
        end
    endgenerate

    assign johnson = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};

    always_comb begin
        stepped_q   = q_q;
        stepped_dir = dir_q;
        case (mode)
            MODE_ROTL: stepped_q = rotl;
            MODE_ROTR: stepped_q = rotr;
            MODE_BOUNCE: begin
                // Reaching an edge turns around within the same step, so the edge bit lights once.
                if (dir_q == DIR_LEFT) begin
                    if (q_q[WIDTH-1]) begin
                        stepped_dir = DIR_RIGHT;
                        stepped_q   = q_q >> 1;
                    end else begin
                        stepped_q   = q_q << 1;
                    end
                end else begin
                    if (q_q[0]) begin
                        stepped_dir = DIR_LEFT;
                        stepped_q   = q_q << 1;
                    end else begin
                        stepped_q   = q_q >> 1;
                    end
                end
            end
            default: stepped_q = johnson;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        if (load) begin
            q_d = load_data;
        end else if (step) begin
            q_d    = stepped_q;
            dir_d  = stepped_dir;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= {{(WIDTH-1){1'b0}}, 1'b1};
            dir_q  <= DIR_LEFT;
            tick_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign Q    = q_q;
    assign dir  = dir_q;
    assign tick = tick_q;

endmodule
